// File: rtl/barcode_drive_ctrl.sv
// barcode_drive_ctrl
//   Sequences the 4-bit leg-enable bus of the barcode/LED sink pad driver.
//   Leg weights are 1,1,1,3 units, so drive levels 0..6 are available.
//   The block ramps the level one unit per ramp tick on start and stop,
//   gates the legs with a frame-based PWM, and shuts down at once on force_off.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   enable     level-sensitive drive request
//   level_tgt  target drive level in units (7 is treated as 6)
//   duty       PWM on-count per frame (0 = always off, all-ones = always on)
//   force_off  immediate shutdown, highest priority
//   ng_en      registered leg enables to the pad driver
//   cur_level  current ramped level, 0..6
//   busy       high whenever the sequencer is not OFF
//   at_level   high in ON when cur_level equals the clamped target
module barcode_drive_ctrl #(
  parameter int RAMP_DIV = 16,
  parameter int PWM_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [2:0]       level_tgt,
  input  logic [PWM_W-1:0] duty,
  input  logic             force_off,
  output logic [3:0]       ng_en,
  output logic [2:0]       cur_level,
  output logic             busy,
  output logic             at_level
);

  typedef enum logic [1:0] {
    S_OFF       = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_ON        = 2'd2,
    S_RAMP_DOWN = 2'd3
  } state_t;

  localparam int              PRE_W   = $clog2(RAMP_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(RAMP_DIV - 1);

  // Level 7 has no leg combination; saturate it to full drive.
  function automatic logic [2:0] clamp_level(input logic [2:0] l);
    return (l == 3'd7) ? 3'd6 : l;
  endfunction

  // Units -> legs. Levels 4..6 use the 3-unit leg plus 1..3 single legs.
  function automatic logic [3:0] level_map(input logic [2:0] l);
    logic [3:0] m;
    case (l)
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      3'd3:    m = 4'b0111;
      3'd4:    m = 4'b1001;
      3'd5:    m = 4'b1011;
      3'd6:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  state_t           state, next_state;
  logic [PRE_W-1:0] presc;
  logic [PWM_W-1:0] pwm_cnt;
  logic [2:0]       tgt;
  logic             tick;
  logic             pwm_on;
  logic [2:0]       level_nxt;
  logic [3:0]       ng_en_nxt;
  logic             busy_nxt;
  logic             at_level_nxt;

  assign tgt    = clamp_level(level_tgt);
  assign tick   = (state != S_OFF) && (presc == PRE_MAX);
  assign pwm_on = (duty == {PWM_W{1'b1}}) || (pwm_cnt < duty);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_OFF;
    else        state <= next_state;
  end

  // Next-state logic. RAMP_UP looks at the level being written this cycle so
  // ON and at_level line up with the final step; RAMP_DOWN looks at the
  // registered level so busy drops one cycle after the level reaches 0.
  always_comb begin
    next_state = state;
    if (force_off) begin
      next_state = S_OFF;
    end else begin
      case (state)
        S_OFF:       if (enable) next_state = S_RAMP_UP;
        S_RAMP_UP: begin
          if (!enable)                next_state = S_RAMP_DOWN;
          else if (level_nxt >= tgt)  next_state = S_ON;
        end
        S_ON:        if (!enable) next_state = S_RAMP_DOWN;
        S_RAMP_DOWN: begin
          if (enable)                 next_state = S_RAMP_UP;
          else if (cur_level == 3'd0) next_state = S_OFF;
        end
        default:     next_state = S_OFF;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    level_nxt = cur_level;
    if (force_off || state == S_OFF) begin
      level_nxt = 3'd0;
    end else if (tick) begin
      case (state)
        S_RAMP_UP:   if (cur_level < tgt) level_nxt = cur_level + 3'd1;
        S_ON: begin
          if (cur_level < tgt)      level_nxt = cur_level + 3'd1;
          else if (cur_level > tgt) level_nxt = cur_level - 3'd1;
        end
        S_RAMP_DOWN: if (cur_level != 3'd0) level_nxt = cur_level - 3'd1;
        default:     level_nxt = cur_level;
      endcase
    end

    busy_nxt     = (next_state != S_OFF);
    at_level_nxt = (next_state == S_ON) && (level_nxt == tgt);

    // Legs follow the registered level, so they trail cur_level by a cycle.
    ng_en_nxt = 4'b0000;
    if (!force_off && state != S_OFF && pwm_on) ng_en_nxt = level_map(cur_level);
  end

  // Registered outputs, ramp prescaler and PWM frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ng_en     <= 4'b0000;
      cur_level <= 3'd0;
      busy      <= 1'b0;
      at_level  <= 1'b0;
      presc     <= '0;
      pwm_cnt   <= '0;
    end else begin
      ng_en     <= ng_en_nxt;
      cur_level <= level_nxt;
      busy      <= busy_nxt;
      at_level  <= at_level_nxt;

      if (next_state == S_OFF)  presc <= '0;
      else if (state != S_OFF)  presc <= (presc == PRE_MAX) ? '0 : presc + 1'b1;

      if (next_state == S_OFF)  pwm_cnt <= '0;
      else if (state != S_OFF)  pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

endmodule
